// File: rtl/kl_pipe_pkg.sv
// Shared pipeline definitions: default widths and the slot record carried by the
// S0/S1 pipeline registers.
package kl_pipe_pkg;

   localparam int unsigned INST_W = 16;
   localparam int unsigned ADDR_W = 8;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } inst_slot_t;

endpackage

// File: rtl/inst_ring.sv
// Synchronous ring buffer with a 2-wide push, 0..2-wide pop and a flush.
// The two oldest entries are always visible on head0_o/head1_o.
module inst_ring #(
   parameter int unsigned W     = 24,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [W-1:0]     push_data0_i,
   input  logic [W-1:0]     push_data1_i,
   input  logic [1:0]       pop_n_i,
   output logic [CNT_W-1:0] count_o,
   output logic [W-1:0]     head0_o,
   output logic [W-1:0]     head1_o
);

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             wr_en_c;

   assign wr_en_c = push_i && !flush_i && rst_n;

   // Pointer and occupancy update; flush collapses the read side onto the write side.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush_i) begin
         rd_d    = wr_q;
         count_d = '0;
      end else begin
         rd_d = rd_q + PTR_W'(pop_n_i);
         if (push_i) begin
            wr_d = wr_q + PTR_W'(2);
         end
         count_d = count_q + (push_i ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: occupancy alone decides what is live.
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_q]              <= push_data0_i;
         mem_q[wr_q + PTR_W'(1)]  <= push_data1_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush_i) begin
         assert (32'(pop_n_i) <= 32'(count_q));
         assert (!push_i || (32'(count_q) + 32'd2 - 32'(pop_n_i) <= DEPTH));
      end
   end

   assign count_o = count_q;
   assign head0_o = mem_q[rd_q];
   assign head1_o = mem_q[rd_q + PTR_W'(1)];

endmodule

// File: rtl/dual_fetch_queue.sv
// Fetch/queue stage feeding DECODE (S0) of both issue pipes: fetches instruction pairs
// into a ring and hands the two oldest to P0/P1 when the hazard unit allows.
module dual_fetch_queue #(
   parameter int unsigned INST_W = kl_pipe_pkg::INST_W,
   parameter int unsigned ADDR_W = kl_pipe_pkg::ADDR_W,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    fetch_next,
   input  logic                    redirect_valid,
   input  logic [ADDR_W-1:0]       redirect_pc,
   output logic                    imem_req,
   output logic [ADDR_W-1:0]       imem_addr,
   input  logic [2*INST_W-1:0]     imem_rdata,
   output logic                    s0_p0_valid,
   output logic [ADDR_W-1:0]       s0_p0_pc,
   output logic [INST_W-1:0]       s0_p0_inst,
   output logic                    s0_p1_valid,
   output logic [ADDR_W-1:0]       s0_p1_pc,
   output logic [INST_W-1:0]       s0_p1_inst,
   output logic [$clog2(DEPTH):0]  queue_count
);

   import kl_pipe_pkg::inst_slot_t;

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned ENT_W = ADDR_W + INST_W;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   inst_slot_t        p0_q, p0_d;
   inst_slot_t        p1_q, p1_d;

   logic [CNT_W-1:0]  count;
   logic [ENT_W-1:0]  head0, head1;
   logic [ENT_W-1:0]  push_data0, push_data1;
   logic [ADDR_W-1:0] pair_pc_c;
   logic              space_ok_c;
   logic              push_c;
   logic              issue_c;
   logic [1:0]        pop_n_c;

   // Reserve room for both the pair already in flight and the one about to be requested.
   assign space_ok_c = (32'(count) + (inflight_q ? 32'd2 : 32'd0)) <= 32'(DEPTH - 2);
   assign imem_req   = rst_n && !redirect_valid && space_ok_c;
   assign imem_addr  = fetch_pc_q;

   // fetch_pc has already stepped past the pair now returning.
   assign pair_pc_c  = fetch_pc_q - ADDR_W'(2);
   assign push_c     = inflight_q && !redirect_valid;
   assign push_data0 = {pair_pc_c,               imem_rdata[INST_W-1:0]};
   assign push_data1 = {pair_pc_c + ADDR_W'(1),  imem_rdata[2*INST_W-1:INST_W]};

   assign issue_c = fetch_next && !redirect_valid;

   always_comb begin
      pop_n_c = 2'd0;
      if (issue_c) begin
         pop_n_c = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
      end
   end

   inst_ring #(
      .W     (ENT_W),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (redirect_valid),
      .push_i       (push_c),
      .push_data0_i (push_data0),
      .push_data1_i (push_data1),
      .pop_n_i      (pop_n_c),
      .count_o      (count),
      .head0_o      (head0),
      .head1_o      (head1)
   );

   // Fetch address and in-flight tracking.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = imem_req;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (imem_req) begin
         fetch_pc_d = fetch_pc_q + ADDR_W'(2);
      end
   end

   // S0 slots: oldest entry goes to P0; held unchanged while the hazard unit stalls.
   always_comb begin
      p0_d = p0_q;
      p1_d = p1_q;
      if (redirect_valid) begin
         p0_d.valid = 1'b0;
         p1_d.valid = 1'b0;
      end else if (fetch_next) begin
         p0_d.valid = (pop_n_c != 2'd0);
         p1_d.valid = (pop_n_c == 2'd2);
         if (pop_n_c != 2'd0) begin
            p0_d.pc   = head0[ENT_W-1 -: ADDR_W];
            p0_d.inst = head0[INST_W-1:0];
         end
         if (pop_n_c == 2'd2) begin
            p1_d.pc   = head1[ENT_W-1 -: ADDR_W];
            p1_d.inst = head1[INST_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= '0;
         inflight_q <= 1'b0;
         p0_q       <= '0;
         p1_q       <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         p0_q       <= p0_d;
         p1_q       <= p1_d;
      end
   end

   assign s0_p0_valid = p0_q.valid;
   assign s0_p0_pc    = p0_q.pc;
   assign s0_p0_inst  = p0_q.inst;
   assign s0_p1_valid = p1_q.valid;
   assign s0_p1_pc    = p1_q.pc;
   assign s0_p1_inst  = p1_q.inst;
   assign queue_count = count;

endmodule

// File: tb/tb_dual_fetch_queue.sv
// Scoreboard bench for dual_fetch_queue: a queue-level reference model predicts fetches,
// occupancy and the issued instruction stream; a separate monitor checks the S0 slots.
module tb_dual_fetch_queue;

   localparam int unsigned INST_W = 16;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DEPTH  = 8;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 fetch_next;
   logic                 redirect_valid;
   logic [ADDR_W-1:0]    redirect_pc;
   logic                 imem_req;
   logic [ADDR_W-1:0]    imem_addr;
   logic [2*INST_W-1:0]  imem_rdata;
   logic                 s0_p0_valid, s0_p1_valid;
   logic [ADDR_W-1:0]    s0_p0_pc, s0_p1_pc;
   logic [INST_W-1:0]    s0_p0_inst, s0_p1_inst;
   logic [3:0]           queue_count;

   always #5 clk = ~clk;

   dual_fetch_queue #(
      .INST_W (INST_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_next     (fetch_next),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .s0_p0_valid    (s0_p0_valid),
      .s0_p0_pc       (s0_p0_pc),
      .s0_p0_inst     (s0_p0_inst),
      .s0_p1_valid    (s0_p1_valid),
      .s0_p1_pc       (s0_p1_pc),
      .s0_p1_inst     (s0_p1_inst),
      .queue_count    (queue_count)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } ent_t;

   ent_t        mq[$];     // model of queued instructions, oldest first
   ent_t        exp_q[$];  // instructions the model expects to reach S0, in order
   int          rec_q[$];  // per-cycle S0 expectation: -1 = hold, else entries loaded
   logic [7:0]  m_fpc;
   logic [7:0]  m_pend;
   logic        m_inf;
   logic        m_known;
   int          checks = 0;
   int          passes = 0;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      return (16'(a) * 16'd40503) ^ 16'h3C5A;
   endfunction

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // One clock cycle: drive inputs, check fetch side, then advance the model.
   task automatic step(input logic rn, input logic fn, input logic rv, input logic [7:0] rpc);
      logic req_m;
      int   n;
      @(negedge clk);
      rst_n          = rn;
      fetch_next     = fn;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (m_inf) imem_rdata = {mem_word(m_pend + 8'd1), mem_word(m_pend)};
      else       imem_rdata = $urandom;
      #1;
      req_m = rn && !rv && (mq.size() + 2 * int'(m_inf) <= int'(DEPTH) - 2);
      chk("imem_req", 64'(imem_req), 64'(req_m));
      if (req_m && m_known) chk("imem_addr", 64'(imem_addr), 64'(m_fpc));
      if (m_known) chk("queue_count", 64'(queue_count), 64'(mq.size()));
      @(posedge clk);
      if (!rn) begin
         mq.delete();
         m_fpc   = 8'd0;
         m_inf   = 1'b0;
         m_known = 1'b1;
         rec_q.push_back(0);
      end else if (rv) begin
         mq.delete();
         m_fpc = rpc;
         m_inf = 1'b0;
         rec_q.push_back(0);
      end else begin
         if (fn) begin
            n = (mq.size() < 2) ? mq.size() : 2;
            repeat (n) exp_q.push_back(mq.pop_front());
            rec_q.push_back(n);
         end else begin
            rec_q.push_back(-1);
         end
         if (m_inf) begin
            mq.push_back({m_pend, mem_word(m_pend)});
            mq.push_back({m_pend + 8'd1, mem_word(m_pend + 8'd1)});
         end
         m_inf = req_m;
         if (req_m) begin
            m_pend = m_fpc;
            m_fpc  = m_fpc + 8'd2;
         end
      end
   endtask

   // Monitor: consumes one expectation per cycle and compares the S0 slots.
   initial begin
      logic [49:0] last, cur;
      int          r;
      ent_t        e;
      last = '0;
      forever begin
         @(negedge clk);
         if (rec_q.size() != 0) begin
            r   = rec_q.pop_front();
            cur = {s0_p0_valid, s0_p0_pc, s0_p0_inst, s0_p1_valid, s0_p1_pc, s0_p1_inst};
            if (r < 0) begin
               chk("s0_hold", 64'(cur), 64'(last));
            end else begin
               chk("s0_p0_valid", 64'(s0_p0_valid), 64'(r >= 1));
               chk("s0_p1_valid", 64'(s0_p1_valid), 64'(r == 2));
               if (r >= 1 && exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("s0_p0_pc",   64'(s0_p0_pc),   64'(e.pc));
                  chk("s0_p0_inst", 64'(s0_p0_inst), 64'(e.inst));
               end
               if (r == 2 && exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("s0_p1_pc",   64'(s0_p1_pc),   64'(e.pc));
                  chk("s0_p1_inst", 64'(s0_p1_inst), 64'(e.inst));
               end
            end
            last = cur;
         end
      end
   end

   initial begin
      rst_n          = 1'b0;
      fetch_next     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rdata     = '0;
      m_fpc          = 8'd0;
      m_pend         = 8'd0;
      m_inf          = 1'b0;
      m_known        = 1'b0;

      repeat (2) step(1'b0, 1'b1, 1'b0, 8'h00);
      #2;
      chk("reset_count", 64'(queue_count), 64'd0);
      chk("reset_p0", {14'd0, s0_p0_valid, s0_p0_pc, s0_p0_inst, 25'd0}, 64'd0);
      chk("reset_p1", {39'd0, s0_p1_valid, s0_p1_pc, s0_p1_inst}, 64'd0);

      // Streaming with fetch_next held high.
      repeat (12) step(1'b1, 1'b1, 1'b0, 8'h00);

      // Stall until the queue fills, then resume.
      repeat (6) step(1'b1, 1'b0, 1'b0, 8'h00);
      #2;
      chk("stall_full", 64'(queue_count), 64'(DEPTH));
      repeat (10) step(1'b1, 1'b1, 1'b0, 8'h00);

      // Redirect while a request is outstanding.
      step(1'b1, 1'b1, 1'b1, 8'h41);
      repeat (6) step(1'b1, 1'b1, 1'b0, 8'h00);

      // Redirect near the top of the address space to exercise wrap.
      step(1'b1, 1'b1, 1'b1, 8'hFE);
      repeat (8) step(1'b1, 1'b1, 1'b0, 8'h00);

      // Randomized traffic: stalls, redirects and occasional mid-fetch reset.
      repeat (400) begin
         step(($urandom % 100) != 0, ($urandom % 100) < 65, ($urandom % 100) < 5, 8'($urandom));
      end

      repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
